// File: rtl/missionary_cannibal_fsm_if.sv
// Bank-count bundle driven by the river-crossing sequencer.
// The sequencer drives it through the master modport; display logic reads it
// through the slave modport.
interface missionary_cannibal_fsm_if;
    logic [1:0] missionary_next;
    logic [1:0] cannibal_next;
    logic [2:0] finish;

    modport master (
        output missionary_next,
        output cannibal_next,
        output finish
    );

    modport slave (
        input missionary_next,
        input cannibal_next,
        input finish
    );
endinterface

// File: rtl/missionary_cannibal_fsm.sv
// Free-running Moore sequencer for the 3-missionary / 3-cannibal crossing.
// It walks the fixed 11-crossing solution one state per clock and then
// restarts. Even states have the boat on the left bank and odd states have it
// on the right. The outputs are the left-bank head counts and a one-cycle
// finish flag in the final state.
module missionary_cannibal_fsm (
    input  logic                          clock,
    input  logic                          reset,
    missionary_cannibal_fsm_if.master     bus
);

    typedef enum logic [3:0] {
        STATE_0  = 4'd0,
        STATE_1  = 4'd1,
        STATE_2  = 4'd2,
        STATE_3  = 4'd3,
        STATE_4  = 4'd4,
        STATE_5  = 4'd5,
        STATE_6  = 4'd6,
        STATE_7  = 4'd7,
        STATE_8  = 4'd8,
        STATE_9  = 4'd9,
        STATE_10 = 4'd10,
        STATE_11 = 4'd11
    } state_t;

    // The initial value sets the power-up state on FPGA targets without a reset pulse.
    state_t     current_state = STATE_0;
    state_t     next_state_s;
    logic [1:0] missionary_s;
    logic [1:0] cannibal_s;
    logic [2:0] finish_s;

    // State register: synchronous reset wins over the advance on any edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            current_state <= STATE_0;
        end else begin
            current_state <= next_state_s;
        end
    end

    // Next-state: step forward, wrap after the final crossing, recover from illegal codes.
    always_comb begin
        next_state_s = STATE_0;
        case (current_state)
            STATE_0:  next_state_s = STATE_1;
            STATE_1:  next_state_s = STATE_2;
            STATE_2:  next_state_s = STATE_3;
            STATE_3:  next_state_s = STATE_4;
            STATE_4:  next_state_s = STATE_5;
            STATE_5:  next_state_s = STATE_6;
            STATE_6:  next_state_s = STATE_7;
            STATE_7:  next_state_s = STATE_8;
            STATE_8:  next_state_s = STATE_9;
            STATE_9:  next_state_s = STATE_10;
            STATE_10: next_state_s = STATE_11;
            STATE_11: next_state_s = STATE_0;
            default:  next_state_s = STATE_0;
        endcase
    end

    // Output decode: left-bank counts per state; illegal codes look like STATE_0.
    always_comb begin
        missionary_s = 2'd3;
        cannibal_s   = 2'd3;
        finish_s     = 3'b000;
        case (current_state)
            STATE_0:  begin missionary_s = 2'd3; cannibal_s = 2'd3; end
            STATE_1:  begin missionary_s = 2'd3; cannibal_s = 2'd1; end
            STATE_2:  begin missionary_s = 2'd3; cannibal_s = 2'd2; end
            STATE_3:  begin missionary_s = 2'd3; cannibal_s = 2'd0; end
            STATE_4:  begin missionary_s = 2'd3; cannibal_s = 2'd1; end
            STATE_5:  begin missionary_s = 2'd1; cannibal_s = 2'd1; end
            STATE_6:  begin missionary_s = 2'd2; cannibal_s = 2'd2; end
            STATE_7:  begin missionary_s = 2'd0; cannibal_s = 2'd2; end
            STATE_8:  begin missionary_s = 2'd0; cannibal_s = 2'd3; end
            STATE_9:  begin missionary_s = 2'd0; cannibal_s = 2'd1; end
            STATE_10: begin missionary_s = 2'd0; cannibal_s = 2'd2; end
            STATE_11: begin missionary_s = 2'd0; cannibal_s = 2'd0; finish_s = 3'b001; end
            default:  begin missionary_s = 2'd3; cannibal_s = 2'd3; finish_s = 3'b000; end
        endcase
    end

    assign bus.missionary_next = missionary_s;
    assign bus.cannibal_next   = cannibal_s;
    assign bus.finish          = finish_s;

endmodule

// File: tb/tb_missionary_cannibal_fsm.sv
// Scoreboard bench for the river-crossing sequencer. The driver pushes the
// hand-computed expected state for each edge. The monitor pops one entry after
// each edge and compares the state and all outputs.
module tb_missionary_cannibal_fsm;

    logic clock;
    logic reset;

    missionary_cannibal_fsm_if bus ();

    missionary_cannibal_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [1:0] m;
        logic [1:0] c;
        logic [2:0] f;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // Hand-written solution table: left-bank missionaries and cannibals per state.
    logic [1:0] m_tab [12];
    logic [1:0] c_tab [12];

    initial begin
        m_tab = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        c_tab = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
    end

    // Drive reset for the next rising edge and record the expected state after that edge.
    task automatic step(input logic r, input int idx, input string tag);
        exp_t e;
        @(negedge clock);
        reset = r;
        e.idx = idx;
        e.m   = m_tab[idx];
        e.c   = c_tab[idx];
        e.f   = (idx == 11) ? 3'b001 : 3'b000;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: 1 ns after each rising edge, compare the DUT against the oldest expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "_state"}, int'(dut.current_state), e.idx);
            check({e.tag, "_m"},     int'(bus.missionary_next), int'(e.m));
            check({e.tag, "_c"},     int'(bus.cannibal_next),   int'(e.c));
            check({e.tag, "_f"},     int'(bus.finish),          int'(e.f));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;

        // Reset state.
        step(1'b1, 0, "reset");

        // Full sequence after release.
        for (int k = 1; k <= 11; k++) step(1'b0, k, "seq");

        // Auto-restart from the final state.
        step(1'b0, 0, "restart0");
        step(1'b0, 1, "restart1");

        // Mid-run reset at STATE_5.
        step(1'b1, 0, "pre_mid");
        for (int k = 1; k <= 5; k++) step(1'b0, k, "to5");
        step(1'b1, 0, "mid_reset");
        step(1'b0, 1, "mid_release");

        // Extended run of two full periods.
        step(1'b1, 0, "ext_reset");
        for (int k = 1; k <= 24; k++) step(1'b0, k % 12, "ext");

        // Reset applied while in the final state.
        for (int k = 1; k <= 11; k++) step(1'b0, k, "to11");
        step(1'b1, 0, "final_reset");
        step(1'b0, 1, "final_release");

        // Let the monitor drain, then confirm every expectation was consumed.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/missionary_cannibal_fsm.md
Name: missionary_cannibal_fsm

Overview:
- Free-running Moore FSM that steps through the fixed 11-crossing solution of the 3-missionary / 3-cannibal river-crossing puzzle, one state per clock.
- Each state drives the left-bank missionary and cannibal counts plus a finish flag.
- Used as a self-contained sequencer feeding display/LED logic on the FPGA.
- Restarts automatically after the final state.

Parameters:
None.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset; sampled on rising edge of clock
missionary_next  output  2  missionaries on left bank in current state (0..3)
cannibal_next  output  2  cannibals on left bank in current state (0..3)
finish  output  3  3'b001 in final state, 3'b000 otherwise; bits [2:1] always 0

Behaviour:
- One clock domain: clock. Reset is synchronous and active-high: on a rising edge with reset=1, the state register loads STATE_0. No asynchronous reset path.
- State register:
  - Internal 4-bit register named current_state; the bench probes it hierarchically.
  - Power-up/initial value is STATE_0.
- Outputs are pure combinational decode of current_state (Moore); they change only after a clock edge, with no dependency on reset level.
- State table (index: boat side, M, C, finish):
  - 0: L, 3 (11), 3 (11), 000
  - 1: R, 3 (11), 1 (01), 000
  - 2: L, 3 (11), 2 (10), 000
  - 3: R, 3 (11), 0 (00), 000
  - 4: L, 3 (11), 1 (01), 000
  - 5: R, 1 (01), 1 (01), 000
  - 6: L, 2 (10), 2 (10), 000
  - 7: R, 0 (00), 2 (10), 000
  - 8: L, 0 (00), 3 (11), 000
  - 9: R, 0 (00), 1 (01), 000
  - 10: L, 0 (00), 2 (10), 000
  - 11: R, 0 (00), 0 (00), 001 (FINAL)
- Boat side is implied by the state index (even = left, odd = right) and is not an output.
- Transitions:
  - With reset=0, each rising edge advances N -> N+1 for N = 0..10.
  - STATE_11 -> STATE_0 (auto-restart); no hold in the final state.
  - Full period is 12 clocks.
- Reset priority: reset=1 overrides the advance on the same edge, from any state, including mid-sequence and STATE_11.
- Reset release: the first rising edge with reset=0 after a reset edge moves STATE_0 -> STATE_1.
- Illegal encodings 12..15:
  - Outputs decode as STATE_0 (M=11, C=11, finish=000).
  - The next edge loads STATE_0.
- finish is high for exactly one clock per 12-cycle period.
- No inputs other than clock and reset; no handshake.

Test Plan:
- Reset: hold reset=1 across one rising edge, sample 1 ns after -> M=11, C=11, F=000, current_state=0.
- Full sequence: release reset, then 11 edges -> outputs match states 1..11 in order. State 11 gives M=00, C=00, F=001; all earlier states give F=000.
- Auto-restart: one more edge after STATE_11 -> M=11, C=11, F=000; the next edge gives state 1 (M=11, C=01).
- Mid-run reset: from STATE_0 run 5 edges to STATE_5 (M=01, C=01), then assert reset for one edge -> STATE_0. After release, the next edge gives STATE_1.
- Extended run: after reset release, 24 edges -> edge k shows state ((k) mod 12). F=001 only at k=11 and k=23; zero mismatches.
- Reset at final state: assert reset on the edge while in STATE_11 -> STATE_0. No extra cycle, and finish drops to 000.
